// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
// sched_pkg : shared sizes and FSM state type for the rr_sched16 scheduler
// Rev 1.0
// ============================================================================
package sched_pkg;
  localparam int N_REQ = 16;
  localparam int ID_W  = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;
endpackage
`default_nettype wire

// File: rtl/prio_enc16.sv
`default_nettype none
// ============================================================================
// prio_enc16 : combinational highest-set-index encoder, y=0 when no bit set
// Rev 1.0
// ============================================================================
module prio_enc16
  import sched_pkg::*;
(
  input  logic [N_REQ-1:0] d,
  output logic [ID_W-1:0]  y,
  output logic             vld
);

  always_comb begin
    y   = '0;
    vld = |d;
    // Ascending scan: the last hit is the highest set index.
    for (int i = 0; i < N_REQ; i++) begin
      if (d[i]) y = ID_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_sched16.sv
`default_nettype none
// ============================================================================
// rr_sched16 : 16-requester round-robin scheduler with done/drop/hold-limit release
// Rev 1.0
// ============================================================================
module rr_sched16
  import sched_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0] HOLD_SAT  = 8'(MAX_HOLD);

  state_t           state, state_nx;
  logic [ID_W-1:0]  last_id, last_id_nx;
  logic [7:0]       hold_cnt, hold_cnt_nx;
  logic [N_REQ-1:0] gnt_nx;
  logic [ID_W-1:0]  gnt_id_nx;
  logic             gnt_vld_nx, timeout_nx;

  logic [N_REQ-1:0] masked;
  logic [ID_W-1:0]  m_y, r_y, winner;
  logic             m_vld, r_vld;

  // Only indices strictly below the previous winner compete first.
  assign masked = req & ((N_REQ'(1) << last_id) - N_REQ'(1));
  assign winner = m_vld ? m_y : r_y;

  prio_enc16 u_enc_masked (.d(masked), .y(m_y), .vld(m_vld));
  prio_enc16 u_enc_req    (.d(req),    .y(r_y), .vld(r_vld));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_id  <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      last_id  <= last_id_nx;
      hold_cnt <= hold_cnt_nx;
      gnt      <= gnt_nx;
      gnt_id   <= gnt_id_nx;
      gnt_vld  <= gnt_vld_nx;
      timeout  <= timeout_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    last_id_nx  = last_id;
    hold_cnt_nx = hold_cnt;
    gnt_nx      = gnt;
    gnt_id_nx   = gnt_id;
    gnt_vld_nx  = gnt_vld;
    timeout_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (r_vld) begin
          state_nx    = OWN;
          gnt_nx      = N_REQ'(1) << winner;
          gnt_id_nx   = winner;
          gnt_vld_nx  = 1'b1;
          hold_cnt_nx = '0;
          last_id_nx  = winner;
        end
      end
      OWN: begin
        if (done || !req[gnt_id]) begin
          state_nx   = IDLE;
          gnt_nx     = '0;
          gnt_vld_nx = 1'b0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx   = IDLE;
          gnt_nx     = '0;
          gnt_vld_nx = 1'b0;
          timeout_nx = 1'b1;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_cnt_nx = hold_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/rr_sched16.md
# rr_sched16

Sixteen-requester round-robin scheduler that shares one downstream resource (bus port, shared datapath slot) among requesters `req[15:0]`. Arbitration uses a highest-index-wins priority encode on a masked request vector, so ties resolve toward bit 15 and the starting point rotates after each grant. A granted requester owns the resource until it signals `done`, drops its request, or exceeds a programmable hold limit. The block sits between the requesting agents and the shared resource's select mux.

## Interface
- `N_REQ`, 16: number of requesters. Fixed at 16 in this revision.
- `MAX_HOLD`, 8: maximum number of cycles a grant is held before forced release. Legal range is 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  16  request vector; bit i is high while requester i wants the resource.
- `done`  in  1  owner finished; one-cycle pulse, meaningful only while `gnt_vld`=1.
- `gnt`  out  16  one-hot grant; all zero when idle.
- `gnt_id`  out  4  binary index of the current owner; holds its last value when idle.
- `gnt_vld`  out  1  a grant is active.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly released.

## Operation
- **Reset values:** `gnt`=0, `gnt_id`=0, `gnt_vld`=0, `timeout`=0, state=IDLE, `last_id`=0, `hold_cnt`=0.
- **State machine:** two states, IDLE and OWN.
- **IDLE:**
  - `masked = req & ((1<<last_id)-1)`, i.e. only indices strictly below `last_id`.
  - If `masked`≠0, the winner is the highest set bit of `masked`.
  - Otherwise, if `req`≠0, the winner is the highest set bit of `req` (wrap-around).
  - On a win: register `gnt`=onehot(winner), `gnt_id`=winner, `gnt_vld`=1, `hold_cnt`=0, `last_id`=winner, and go to OWN.
  - If `req`=0, stay in IDLE.
- **OWN:** each cycle, `hold_cnt` increments (saturating at `MAX_HOLD`). Release occurs on the first of these:
  - (a) `done`=1.
  - (b) `req[gnt_id]`=0.
  - (c) `hold_cnt`=`MAX_HOLD`-1 with neither (a) nor (b): forced release, and `timeout` pulses for one cycle.
- **On release:** `gnt`=0, `gnt_vld`=0, go to IDLE. `gnt_id` and `last_id` are retained.
- **After reset:** `last_id`=0 gives an empty mask, so the first arbitration is pure fixed priority (bit 15 highest).
- **Fairness:** after any requester is served, every other continuously-requesting index is served before it is served again.

## Timing
- **Grant latency:** `req` seen high at edge t while IDLE, so `gnt`/`gnt_vld` are high after edge t (visible during cycle t+1). Latency is 1 cycle.
- **Release latency:**
  - `done` or a request drop sampled at edge t clears `gnt` after edge t.
  - The next grant can be issued after edge t+1, so there is exactly one idle cycle between owners.
- **Hold limit:** maximum hold is exactly `MAX_HOLD` cycles of `gnt_vld`=1. The `timeout` pulse coincides with the first `gnt_vld`=0 cycle.
- **Simultaneous events:**
  - `done` together with the timeout condition: `done` wins and `timeout` stays 0.
  - `done` together with a request drop: a single normal release.
- `done` while IDLE is ignored.
- Changes on `req` for non-owners during OWN have no effect until IDLE.
- **Reset mid-grant:** outputs clear immediately (asynchronously). No `timeout` pulse is produced.

## Structure
- **Shared package `sched_pkg`:** `N_REQ`=16, `ID_W`=4, and the state enum `{IDLE, OWN}`.
- **One sub-module:** `prio_enc16`, a purely combinational block.
  - Input: `d[15:0]`.
  - Outputs: `y[3:0]` (highest set index) and `vld` (any bit set). `y`=0 when `vld`=0, never X.
  - Instantiated twice, once for `masked` and once for `req`.
- The remaining logic is the FSM, `hold_cnt` (8 bits), and the `last_id` register.

## Test plan
1. **Reset and first grant:** after reset, `req`=16'h8001 → `gnt`=16'h8000, `gnt_id`=15 one cycle later.
2. **Round-robin order:**
   - Stimulus: `req`=16'h8421 held, with `done` pulsed on the second owned cycle of each grant.
   - Required grant order: 15, 10, 5, 0, 15, with one idle cycle between grants.
3. **Timeout:**
   - Stimulus: `MAX_HOLD`=8, `req`=16'h0010 held, `done` never asserted.
   - Required response: `gnt_vld` high for exactly 8 cycles, then `timeout`=1 for one cycle, then a regrant of index 4 one cycle later.
4. **Done versus timeout collision:** `done`=1 on the 8th owned cycle → release with `timeout`=0.
5. **Request drop:** owner 7 deasserts `req[7]` on its 3rd owned cycle → `gnt`=0 the next cycle, with no `timeout` pulse.
6. **Asynchronous reset mid-grant:** `rst` pulse while `gnt`=16'h0200 → all outputs 0 before the next clock edge; the next arbitration restarts at fixed priority.
